// File: rtl/wb_cache_arbiter.sv
// wb_cache_arbiter: sequences icache fills, dcache fills and uncached accesses onto one Wishbone master port
module wb_cache_arbiter #(
  parameter int TIMEOUT      = 255,
  parameter int STARVE_LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ic_req,
  input  logic [31:0]  i_ic_adr,
  output logic         o_ic_ready,
  input  logic         i_dc_req,
  input  logic [31:0]  i_dc_adr,
  output logic         o_dc_ready,
  input  logic         i_du_req,
  input  logic [31:0]  i_du_adr,
  input  logic         i_du_we,
  input  logic [15:0]  i_du_sel,
  input  logic [127:0] i_du_wdata,
  output logic         o_du_ready,
  output logic [127:0] o_rdata,
  output logic         o_bus_err,
  output logic [31:0]  o_wb_adr,
  output logic [15:0]  o_wb_sel,
  output logic         o_wb_we,
  output logic [127:0] o_wb_dat,
  output logic         o_wb_cyc,
  output logic         o_wb_stb,
  input  logic [127:0] i_wb_dat,
  input  logic         i_wb_ack,
  input  logic         i_wb_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  typedef enum logic [1:0] {G_IC, G_DC, G_DU} gnt_t;
  state_t state, state_n;
  gnt_t gnt, win;
  logic [9:0] wdog;
  logic [3:0] starve;
  logic [31:0] fill_adr;
  logic any_req, start, done, fail;
  // Winner selection, termination conditions, next state and ready pulses
  always_comb begin
    any_req    = i_ic_req || i_dc_req || i_du_req;
    win        = (i_ic_req && starve == 4'(STARVE_LIMIT)) ? G_IC : i_du_req ? G_DU : i_dc_req ? G_DC : G_IC;
    fill_adr   = (win == G_IC ? i_ic_adr : i_dc_adr) & 32'hFFFF_FFF0;
    start      = state == IDLE && any_req;
    done       = i_wb_err || i_wb_ack || wdog == 10'(TIMEOUT - 1);
    fail       = i_wb_err || !i_wb_ack;
    state_n    = state == IDLE ? (any_req ? BUSY : IDLE) : state == BUSY ? (done ? RESP : BUSY) : IDLE;
    o_ic_ready = state == RESP && gnt == G_IC;
    o_dc_ready = state == RESP && gnt == G_DC;
    o_du_ready = state == RESP && gnt == G_DU;
  end
  // State register
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_n;
  // Grant latching, bus drive, watchdog, starvation count and response capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gnt       <= G_IC;
      wdog      <= '0;
      starve    <= '0;
      o_wb_adr  <= '0;
      o_wb_sel  <= '0;
      o_wb_we   <= 1'b0;
      o_wb_dat  <= '0;
      o_wb_cyc  <= 1'b0;
      o_wb_stb  <= 1'b0;
      o_rdata   <= '0;
      o_bus_err <= 1'b0;
    end else if (start) begin
      gnt      <= win;
      wdog     <= '0;
      o_wb_cyc <= 1'b1;
      o_wb_stb <= 1'b1;
      o_wb_adr <= win == G_DU ? i_du_adr : fill_adr;
      o_wb_sel <= win == G_DU ? i_du_sel : 16'hFFFF;
      o_wb_we  <= win == G_DU && i_du_we;
      o_wb_dat <= win == G_DU ? i_du_wdata : '0;
      starve   <= win == G_IC ? 4'd0 : (i_ic_req && starve != 4'(STARVE_LIMIT)) ? starve + 4'd1 : starve;
    end else if (state == BUSY) begin
      wdog <= wdog + 10'd1;
      if (done) begin
        o_wb_cyc  <= 1'b0;
        o_wb_stb  <= 1'b0;
        o_rdata   <= fail ? '0 : i_wb_dat;
        o_bus_err <= fail;
      end
    end
  end
endmodule

// File: tb/tb_wb_cache_arbiter.sv
// tb_wb_cache_arbiter: directed and random checks of wb_cache_arbiter against a transaction-level model
module tb_wb_cache_arbiter;
  localparam int TO = 8;
  localparam int SL = 4;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_ic_req = 1'b0, i_dc_req = 1'b0, i_du_req = 1'b0, i_du_we = 1'b0;
  logic i_wb_ack = 1'b0, i_wb_err = 1'b0;
  logic [31:0] i_ic_adr = '0, i_dc_adr = '0, i_du_adr = '0;
  logic [15:0] i_du_sel = '0;
  logic [127:0] i_du_wdata = '0, i_wb_dat = '0;
  logic o_ic_ready, o_dc_ready, o_du_ready, o_bus_err, o_wb_we, o_wb_cyc, o_wb_stb;
  logic [127:0] o_rdata, o_wb_dat;
  logic [31:0] o_wb_adr;
  logic [15:0] o_wb_sel;

  wb_cache_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_ic_req(i_ic_req), .i_ic_adr(i_ic_adr), .o_ic_ready(o_ic_ready),
    .i_dc_req(i_dc_req), .i_dc_adr(i_dc_adr), .o_dc_ready(o_dc_ready),
    .i_du_req(i_du_req), .i_du_adr(i_du_adr), .i_du_we(i_du_we), .i_du_sel(i_du_sel),
    .i_du_wdata(i_du_wdata), .o_du_ready(o_du_ready),
    .o_rdata(o_rdata), .o_bus_err(o_bus_err),
    .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we), .o_wb_dat(o_wb_dat),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Transaction-level model: one outstanding bus transaction, its completion, and the held response
  bit m_on, m_bus, m_resp, m_err;
  int m_cnt, m_starve;
  logic [2:0] m_who;
  logic [31:0] m_adr;
  logic [15:0] m_sel;
  logic m_we;
  logic [127:0] m_dat, m_rdata;
  logic [2:0] glog[$];

  initial forever begin
    @(posedge i_clk);
    if (i_rst) begin
      m_on = 1; m_bus = 0; m_resp = 0; m_starve = 0; m_rdata = '0; m_err = 0; m_who = 3'd0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_bus) begin
      m_cnt++;
      if (i_wb_err || i_wb_ack || m_cnt == TO) begin
        m_bus = 0;
        m_resp = 1;
        m_err = i_wb_err || !i_wb_ack;
        m_rdata = m_err ? '0 : i_wb_dat;
      end
    end else if (i_ic_req || i_dc_req || i_du_req) begin
      m_who = (i_ic_req && m_starve == SL) ? 3'd1 : i_du_req ? 3'd4 : i_dc_req ? 3'd2 : 3'd1;
      if (m_who == 3'd1) m_starve = 0;
      else if (i_ic_req) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
      if (m_who == 3'd4) begin
        m_adr = i_du_adr; m_sel = i_du_sel; m_we = i_du_we; m_dat = i_du_wdata;
      end else begin
        m_adr = (m_who == 3'd1 ? i_ic_adr : i_dc_adr) & 32'hFFFF_FFF0;
        m_sel = 16'hFFFF; m_we = 1'b0; m_dat = '0;
      end
      glog.push_back(m_who);
      m_bus = 1;
      m_cnt = 0;
    end
    @(negedge i_clk);
    if (m_on) begin
      chk("cyc", 128'(o_wb_cyc), 128'(m_bus));
      chk("stb", 128'(o_wb_stb), 128'(m_bus));
      chk("ready", 128'({o_du_ready, o_dc_ready, o_ic_ready}), 128'(m_resp ? m_who : 3'd0));
      chk("rdata", o_rdata, m_rdata);
      chk("bus_err", 128'(o_bus_err), 128'(m_err));
      if (m_bus) begin
        chk("wb_adr", 128'(o_wb_adr), 128'(m_adr));
        chk("wb_sel", 128'(o_wb_sel), 128'(m_sel));
        chk("wb_we", 128'(o_wb_we), 128'(m_we));
        chk("wb_dat", o_wb_dat, m_dat);
      end
    end
  end

  logic [2:0] exp2 [10] = '{3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd0};
  logic [2:0] exp3 [10] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
  logic [2:0] got[$];
  int cnt, mode;
  bit seen, in_txn;

  initial begin
    tick;
    tick;
    chk("rst cyc/stb", 128'({o_wb_cyc, o_wb_stb}), 128'd0);
    chk("rst ready", 128'({o_du_ready, o_dc_ready, o_ic_ready}), 128'd0);
    chk("rst rdata/err", {o_rdata[126:0], o_bus_err}, 128'd0);
    chk("rst wb", 128'({o_wb_adr, o_wb_sel, o_wb_we}), 128'd0);
    chk("rst wb_dat", o_wb_dat, 128'd0);
    i_rst = 0;

    // single icache fill, immediate ack
    i_ic_req = 1; i_ic_adr = 32'h0000_1234;
    tick;
    chk("t1 cyc", 128'(o_wb_cyc), 128'd1);
    chk("t1 adr", 128'(o_wb_adr), 128'h1230);
    chk("t1 sel", 128'(o_wb_sel), 128'hFFFF);
    chk("t1 we", 128'(o_wb_we), 128'd0);
    i_wb_ack = 1; i_wb_dat = {16{8'hAA}};
    tick;
    chk("t1 ready", 128'(o_ic_ready), 128'd1);
    chk("t1 rdata", o_rdata, {16{8'hAA}});
    chk("t1 err", 128'(o_bus_err), 128'd0);
    i_wb_ack = 0; i_ic_req = 0;
    tick;
    chk("t1 idle", 128'({o_wb_cyc, o_ic_ready}), 128'd0);

    // simultaneous du write, dc and ic requests
    i_du_req = 1; i_du_adr = 32'h8000_0004; i_du_sel = 16'h00F0; i_du_we = 1;
    i_du_wdata = {$urandom, $urandom, $urandom, $urandom};
    i_dc_req = 1; i_dc_adr = $urandom; i_ic_req = 1; i_ic_adr = $urandom;
    for (int k = 1; k <= 9; k++) begin
      tick;
      if (k == 1) begin
        chk("t2 du we", 128'(o_wb_we), 128'd1);
        chk("t2 du sel", 128'(o_wb_sel), 128'h00F0);
        chk("t2 du adr", 128'(o_wb_adr), 128'h8000_0004);
      end
      chk($sformatf("t2 ready k%0d", k), 128'({o_du_ready, o_dc_ready, o_ic_ready}), 128'(exp2[k]));
      if (o_du_ready) i_du_req = 0;
      if (o_dc_ready) i_dc_req = 0;
      if (o_ic_ready) i_ic_req = 0;
      i_wb_ack = o_wb_cyc;
    end
    i_wb_ack = 0; i_du_we = 0;

    // starvation: ic and dc both re-request continuously
    got.delete();
    glog.delete();
    i_ic_req = 1; i_dc_req = 1;
    for (int k = 0; k < 40 && got.size() < 10; k++) begin
      tick;
      if (o_dc_ready) got.push_back(3'd2);
      if (o_ic_ready) got.push_back(3'd1);
      i_dc_req = !o_dc_ready && got.size() < 10;
      i_ic_req = !o_ic_ready && got.size() < 10;
      i_wb_ack = o_wb_cyc;
    end
    i_wb_ack = 0; i_ic_req = 0; i_dc_req = 0;
    tick;
    chk("t3 dut grants", 128'(got.size()), 128'd10);
    chk("t3 model grants", 128'(glog.size()), 128'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t3 dut grant %0d", i), 128'(i < got.size() ? got[i] : 3'd7), 128'(exp3[i]));
      chk($sformatf("t3 model grant %0d", i), 128'(i < glog.size() ? glog[i] : 3'd7), 128'(exp3[i]));
    end

    // err and ack together during a dc fill
    i_dc_req = 1; i_dc_adr = $urandom;
    tick;
    chk("t4 cyc", 128'(o_wb_cyc), 128'd1);
    i_wb_err = 1; i_wb_ack = 1; i_wb_dat = {$urandom, $urandom, $urandom, $urandom} | 128'd1;
    tick;
    chk("t4 ready", 128'(o_dc_ready), 128'd1);
    chk("t4 err", 128'(o_bus_err), 128'd1);
    chk("t4 rdata", o_rdata, 128'd0);
    i_wb_err = 0; i_wb_ack = 0; i_dc_req = 0;
    tick;

    // watchdog timeout, then a late ack
    i_ic_req = 1; i_ic_adr = $urandom;
    cnt = 0; seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      tick;
      if (o_wb_cyc) cnt++;
      if (o_ic_ready) begin
        seen = 1;
        chk("t5 err", 128'(o_bus_err), 128'd1);
        i_ic_req = 0;
      end
    end
    chk("t5 ready seen", 128'(seen), 128'd1);
    chk("t5 cyc cycles", 128'(cnt), 128'd8);
    i_wb_ack = 1; i_wb_dat = {4{32'h1234_5678}};
    tick;
    tick;
    i_wb_ack = 0;
    chk("t5 late ack", 128'({o_wb_cyc, o_du_ready, o_dc_ready, o_ic_ready}), 128'd0);
    chk("t5 held err", 128'(o_bus_err), 128'd1);
    chk("t5 held rdata", o_rdata, 128'd0);

    // reset during BUSY
    i_du_req = 1; i_du_adr = $urandom;
    tick;
    chk("t6 cyc", 128'(o_wb_cyc), 128'd1);
    i_rst = 1; i_du_req = 0;
    tick;
    chk("t6 rst bus", 128'({o_wb_cyc, o_wb_stb}), 128'd0);
    chk("t6 rst ready", 128'({o_du_ready, o_dc_ready, o_ic_ready}), 128'd0);
    i_rst = 0;
    tick;
    chk("t6 after rst", 128'({o_wb_cyc, o_du_ready, o_dc_ready, o_ic_ready}), 128'd0);
    i_ic_req = 1; i_ic_adr = 32'h0000_0040;
    tick;
    chk("t6 restart adr", 128'({o_wb_cyc, o_wb_adr}), {95'd0, 1'b1, 32'h40});
    i_wb_ack = 1; i_wb_dat = {$urandom, $urandom, $urandom, $urandom};
    tick;
    chk("t6 restart ready", 128'(o_ic_ready), 128'd1);
    i_wb_ack = 0; i_ic_req = 0;
    tick;

    // random traffic, random slave behaviour, occasional reset
    in_txn = 0; mode = 0;
    for (int c = 0; c < 3000; c++) begin
      tick;
      i_rst = $urandom_range(0, 599) == 0;
      if (i_ic_req && o_ic_ready) i_ic_req = 0;
      else if (!i_ic_req && $urandom_range(0, 2) == 0) begin i_ic_req = 1; i_ic_adr = $urandom; end
      if (i_dc_req && o_dc_ready) i_dc_req = 0;
      else if (!i_dc_req && $urandom_range(0, 2) == 0) begin i_dc_req = 1; i_dc_adr = $urandom; end
      if (i_du_req && o_du_ready) i_du_req = 0;
      else if (!i_du_req && $urandom_range(0, 3) == 0) begin
        i_du_req = 1; i_du_adr = $urandom; i_du_we = 1'($urandom); i_du_sel = 16'($urandom);
        i_du_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (o_wb_cyc) begin
        if (!in_txn) begin in_txn = 1; mode = $urandom_range(0, 9); end
        i_wb_ack = mode == 2 || (mode > 2 && $urandom_range(0, 1) == 0);
        i_wb_err = mode == 1 || mode == 2;
      end else begin
        in_txn = 0;
        i_wb_ack = $urandom_range(0, 7) == 0;
        i_wb_err = $urandom_range(0, 7) == 0;
      end
      i_wb_dat = {$urandom, $urandom, $urandom, $urandom};
    end
    i_rst = 0; i_ic_req = 0; i_dc_req = 0; i_du_req = 0; i_wb_ack = 0; i_wb_err = 0;
    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
